// File: rtl/sequencer_pattern_input_if.sv
// Bus between the step-key front end and its user (CPU side / sequencer kbd_in).
// SEQ_PATTERN_LOCK_EN adds the lock signal.
interface sequencer_pattern_input_if;
  logic [7:0] btn_in;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] pattern_out;
  logic       key_evt;
  logic [2:0] key_idx;
`ifdef SEQ_PATTERN_LOCK_EN
  logic       lock;

  modport master (
    output btn_in, clr, wr_en, wr_data, lock,
    input  pattern_out, key_evt, key_idx
  );
  modport slave (
    input  btn_in, clr, wr_en, wr_data, lock,
    output pattern_out, key_evt, key_idx
  );
`else
  modport master (
    output btn_in, clr, wr_en, wr_data,
    input  pattern_out, key_evt, key_idx
  );
  modport slave (
    input  btn_in, clr, wr_en, wr_data,
    output pattern_out, key_evt, key_idx
  );
`endif
endinterface

// File: rtl/sequencer_pattern_input.sv
// Synchronises and debounces 8 step keys; each clean press toggles a pattern bit.
// Optional SEQ_PATTERN_LOCK_EN: synchronised lock input masks presses.
module sequencer_pattern_input #(
  parameter int unsigned N_KEYS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input logic                      clk,
  input logic                      rst,
  sequencer_pattern_input_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] s1_q, s2_q;
  logic [N_KEYS-1:0] stable_q, stable_d_q;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [N_KEYS-1:0] press;
  logic              any_press;
  logic [2:0]        low_idx;

`ifdef SEQ_PATTERN_LOCK_EN
  logic lock_s1_q, lock_s2_q;
  // Debouncing keeps running while locked, so unlocking with a key held is not a press.
  assign press = lock_s2_q ? '0 : (stable_q & ~stable_d_q);
`else
  assign press = stable_q & ~stable_d_q;
`endif

  assign any_press = |press;

  always_comb begin
    low_idx = bus.key_idx;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (press[i]) low_idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q            <= '0;
      s2_q            <= '0;
      stable_q        <= '0;
      stable_d_q      <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
      bus.pattern_out <= '0;
      bus.key_evt     <= 1'b0;
      bus.key_idx     <= '0;
`ifdef SEQ_PATTERN_LOCK_EN
      lock_s1_q       <= 1'b0;
      lock_s2_q       <= 1'b0;
`endif
    end else begin
      s1_q       <= bus.btn_in;
      s2_q       <= s1_q;
      stable_d_q <= stable_q;
`ifdef SEQ_PATTERN_LOCK_EN
      lock_s1_q  <= bus.lock;
      lock_s2_q  <= lock_s1_q;
`endif
      for (int i = 0; i < N_KEYS; i++) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          stable_q[i] <= s2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end

      // Presses coinciding with clr/wr_en are reported but not applied.
      if (bus.clr)        bus.pattern_out <= '0;
      else if (bus.wr_en) bus.pattern_out <= bus.wr_data;
      else                bus.pattern_out <= bus.pattern_out ^ press;

      bus.key_evt <= any_press;
      bus.key_idx <= low_idx;
    end
  end

endmodule

// File: tb/tb_sequencer_pattern_input.sv
// Directed bench with DEBOUNCE_CYCLES=4; press expectations go through a scoreboard queue.
module tb_sequencer_pattern_input;

  typedef struct packed {
    logic [7:0] pat;
    logic [2:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   evt_cnt  = 0;
  exp_t sb [$];

  sequencer_pattern_input_if bus ();

  sequencer_pattern_input #(
    .N_KEYS         (8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.key_evt) evt_cnt <= evt_cnt + 1;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare DUT press outputs against the oldest scoreboard entry.
  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_evt"}, {31'd0, bus.key_evt}, 32'd1);
      chk({tag, "_pat"}, {24'd0, bus.pattern_out}, {24'd0, e.pat});
      chk({tag, "_idx"}, {29'd0, bus.key_idx}, {29'd0, e.idx});
    end
  endtask

  // Bounded wait for the next key_evt pulse, then compare.
  task automatic wait_evt(input string tag);
    int n = 0;
    while (!bus.key_evt && n < 20) begin
      tick();
      n++;
    end
    if (!bus.key_evt) chk({tag, "_timeout"}, 32'd1, 32'd0);
    else pop_cmp(tag);
  endtask

  initial begin
    int e0;
    rst         = 1'b1;
    bus.btn_in  = '0;
    bus.clr     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
`ifdef SEQ_PATTERN_LOCK_EN
    bus.lock    = 1'b0;
`endif
    tick(2);
    chk("rst_pat", {24'd0, bus.pattern_out}, 32'h0);
    chk("rst_evt", {31'd0, bus.key_evt}, 32'h0);
    chk("rst_idx", {29'd0, bus.key_idx}, 32'h0);

    // Key 0 held from before edge 1: toggle lands after edge 7.
    rst        = 1'b0;
    bus.btn_in = 8'h01;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("k0_pre_e%0d", i), {23'd0, bus.key_evt, bus.pattern_out}, 32'h0);
    end
    sb.push_back('{pat: 8'h01, idx: 3'd0});
    tick();
    pop_cmp("k0_e7");
    tick();
    chk("k0_e8_evt", {31'd0, bus.key_evt}, 32'h0);
    tick(10);
    chk("k0_held_pat", {24'd0, bus.pattern_out}, 32'h01);
    chk("k0_held_evts", evt_cnt, 32'd1);
    bus.btn_in = 8'h00;
    tick(10);
    chk("k0_release_pat", {24'd0, bus.pattern_out}, 32'h01);

    // Three-cycle glitch on key 3 is rejected.
    e0         = evt_cnt;
    bus.btn_in = 8'h08;
    tick(3);
    bus.btn_in = 8'h00;
    tick(12);
    chk("glitch_pat", {24'd0, bus.pattern_out}, 32'h01);
    chk("glitch_evts", evt_cnt, e0);

    // Keys 5 and 2 together: one pulse, lowest index.
    e0         = evt_cnt;
    bus.btn_in = 8'h24;
    sb.push_back('{pat: 8'h25, idx: 3'd2});
    wait_evt("k52");
    tick();
    chk("k52_evt_low", {31'd0, bus.key_evt}, 32'h0);
    bus.btn_in = 8'h00;
    tick(10);
    chk("k52_one_evt", evt_cnt, e0 + 1);
    bus.btn_in = 8'h04;
    sb.push_back('{pat: 8'h21, idx: 3'd2});
    wait_evt("k2_again");
    bus.btn_in = 8'h00;
    tick(10);

    // wr_en on the accepting edge drops the toggle but still reports the press.
    bus.btn_in = 8'h01;
    tick(6);
    chk("wr_pre_pat", {24'd0, bus.pattern_out}, 32'h21);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    sb.push_back('{pat: 8'hA5, idx: 3'd0});
    tick();
    pop_cmp("wr_press");
    bus.wr_en = 1'b0;
    bus.clr   = 1'b1;
    tick();
    chk("clr_pat", {24'd0, bus.pattern_out}, 32'h0);
    bus.clr    = 1'b0;
    bus.btn_in = 8'h00;
    tick(10);

    // Key 7 held, reset at debounce count 2, redebounced afterwards.
    bus.btn_in = 8'h80;
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_pat", {24'd0, bus.pattern_out}, 32'h0);
    chk("rst_mid_evt", {31'd0, bus.key_evt}, 32'h0);
    tick(6);
    chk("k7_e6_pat", {24'd0, bus.pattern_out}, 32'h0);
    sb.push_back('{pat: 8'h80, idx: 3'd7});
    tick();
    pop_cmp("k7_e7");
    bus.btn_in = 8'h00;
    tick(10);

`ifdef SEQ_PATTERN_LOCK_EN
    e0       = evt_cnt;
    bus.lock = 1'b1;
    tick(3);
    bus.btn_in = 8'h02;
    tick(12);
    chk("lock_pat", {24'd0, bus.pattern_out}, 32'h80);
    chk("lock_evts", evt_cnt, e0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h0F;
    tick();
    bus.wr_en = 1'b0;
    chk("lock_wr_pat", {24'd0, bus.pattern_out}, 32'h0F);
    bus.lock = 1'b0;
    tick(12);
    chk("unlock_pat", {24'd0, bus.pattern_out}, 32'h0F);
    chk("unlock_evts", evt_cnt, e0);
    bus.btn_in = 8'h00;
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
